divider_block: RTL and testbench

Sequential 32-bit integer divider producing quotient and remainder, signed or unsigned, one restoring-division bit per clock. It is the inverse companion of the Booth radix-4 `multiplier_block` and sits beside it in the arithmetic blocks directory. Both feed the same execute-stage result mux. A start/busy/done handshake lets the controller stall while a division is in flight.

---
 rtl/divider_block_pkg.sv | 20 ++
 rtl/divider_step.sv | 32 +++
 rtl/divider_block.sv | 173 +++++++++++++++++
 tb/tb_divider_block.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_block_pkg.sv
// Shared definitions for the sequential restoring divider.
package divider_block_pkg;

  // Default operand/result width; the iteration count equals the width.
  localparam int unsigned DefaultWidth = 32;

  // Controller states; encodings are fixed so they match the multiplier's debug view.
  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StDivide = 2'b01,
    StFixup  = 2'b10,
    StDone   = 2'b11
  } div_state_e;

  // A new request is only taken when no division is in flight.
  function automatic logic can_accept(input div_state_e st);
    return (st == StIdle) || (st == StDone);
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, select.
module divider_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The stored partial remainder never reaches 2^WIDTH, so its top bit carries no information.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_i[WIDTH];

  // Keep the trial difference when it is non-negative, otherwise restore the shifted value.
  always_comb begin
    shifted = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_i};
    if (!trial[WIDTH]) begin
      rem_o = trial;
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted;
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider_block.sv
// Sequential signed/unsigned integer divider, one quotient bit per clock,
// with a start/busy/done handshake for the execute-stage controller.
module divider_block
  import divider_block_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZeroDivQuot = '1;

  div_state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;          // partial remainder R
  logic [WIDTH-1:0] quo_q, quo_d;          // working quotient Q, starts as |a|
  logic [WIDTH-1:0] dvs_q, dvs_d;          // divisor magnitude
  logic [WIDTH-1:0] a_q, a_d;              // raw dividend, returned on divide-by-zero
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             b_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;

  assign accept = start && can_accept(state_q);
  assign b_zero = (b == '0);
  // The most negative value negates to itself, which is already its correct unsigned magnitude.
  assign a_mag  = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_mag  = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  divider_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .dvs_i(dvs_q),
    .rem_o(step_rem),
    .quo_o(step_quo)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a zero divisor skips the iterations entirely.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = b_zero ? StFixup : StDivide;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StDivide: begin
        if (cnt_q == LastStep) begin
          state_d = StFixup;
        end
      end
      StFixup: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    busy = (state_q == StDivide) || (state_q == StFixup);
    done = (state_q == StDone);
  end

  // Datapath next-state: operand capture, iteration, and sign/zero fix-up.
  always_comb begin
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    a_d         = a_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    if (accept) begin
      a_d       = a;
      dvs_d     = b_mag;
      neg_quo_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_rem_d = is_signed & a[WIDTH-1];
      zero_d    = b_zero;
      rem_d     = '0;
      quo_d     = a_mag;
      cnt_d     = '0;
      dbz_d     = 1'b0;
    end else if (state_q == StDivide) begin
      rem_d = step_rem;
      quo_d = step_quo;
      // Wraps back to zero after the last step.
      cnt_d = cnt_q + CntW'(1);
    end else if (state_q == StFixup) begin
      if (zero_q) begin
        quotient_d  = ZeroDivQuot;
        remainder_d = a_q;
        dbz_d       = 1'b1;
      end else begin
        quotient_d  = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
        remainder_d = neg_rem_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
        dbz_d       = 1'b0;
      end
    end
  end

  // Datapath and result registers; reset also aborts any division in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      a_q         <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      a_q         <= a_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_block.sv
// Randomised self-checking bench for divider_block against an arithmetic reference model.
module tb_divider_block;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int asserts = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  divider_block #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_signed  (is_signed),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  // Reference: plain 64-bit integer division, which truncates toward zero
  // and gives the remainder the dividend's sign.
  function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input logic ms,
                                output logic [31:0] eq, output logic [31:0] er,
                                output logic ez);
    longint sa;
    longint sb;
    if (mb == 32'd0) begin
      eq = 32'hFFFF_FFFF;
      er = ma;
      ez = 1'b1;
    end else begin
      if (ms) begin
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
      end else begin
        sa = longint'(ma);
        sb = longint'(mb);
      end
      eq = 32'(sa / sb);
      er = 32'(sa % sb);
      ez = 1'b0;
    end
  endfunction

  // Wait from the negedge after the accepting edge until done, counting edges and busy cycles.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  // Issue one request and wait for its result; operand inputs are scrambled once accepted.
  task automatic run_div(input logic [31:0] ta, input logic [31:0] tbv, input logic ts,
                         output logic [31:0] oq, output logic [31:0] orr, output logic oz,
                         output int lat, output int bcnt);
    @(negedge clk);
    start     = 1'b1;
    a         = ta;
    b         = tbv;
    is_signed = ts;
    @(negedge clk);
    start     = 1'b0;
    a         = $urandom;
    b         = $urandom;
    is_signed = 1'($urandom);
    wait_done(lat, bcnt);
    oq  = quotient;
    orr = remainder;
    oz  = div_by_zero;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    a         = '0;
    b         = '0;
    #12;
    asserts++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    asserts++;
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    asserts++;
    if (div_by_zero !== 1'b0) begin
      fails++; $display("FAIL reset_dbz: got %b want 0", div_by_zero);
    end
    asserts++;
    if (quotient !== 32'h0) begin fails++; $display("FAIL reset_quot: got %h want 0", quotient); end
    asserts++;
    if (remainder !== 32'h0) begin
      fails++; $display("FAIL reset_rem: got %h want 0", remainder);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_unsigned_basic();
    logic [31:0] q, r;
    logic z;
    int lat, bc;
    run_div(32'd100, 32'd7, 1'b0, q, r, z, lat, bc);
    asserts++;
    if (q !== 32'd14) begin fails++; $display("FAIL u100_7_quot: got %0d want 14", q); end
    asserts++;
    if (r !== 32'd2) begin fails++; $display("FAIL u100_7_rem: got %0d want 2", r); end
    asserts++;
    if (z !== 1'b0) begin fails++; $display("FAIL u100_7_dbz: got %b want 0", z); end
    asserts++;
    if (lat != 33) begin fails++; $display("FAIL u100_7_latency: got %0d want 33", lat); end
    asserts++;
    if (bc != 33) begin fails++; $display("FAIL u100_7_busy_cycles: got %0d want 33", bc); end
    @(negedge clk);
    asserts++;
    if (done !== 1'b0) begin fails++; $display("FAIL done_one_cycle: got %b want 0", done); end
  endtask

  task automatic test_signed();
    logic [31:0] ta [3] = '{32'hFFFF_FFF9, 32'h0000_0007, 32'h8000_0000};
    logic [31:0] tb [3] = '{32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] eq [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000};
    logic [31:0] er [3] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    logic [31:0] q, r;
    logic z;
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      run_div(ta[i], tb[i], 1'b1, q, r, z, lat, bc);
      asserts++;
      if (q !== eq[i]) begin
        fails++; $display("FAIL signed_quot[%0d]: got %h want %h", i, q, eq[i]);
      end
      asserts++;
      if (r !== er[i]) begin
        fails++; $display("FAIL signed_rem[%0d]: got %h want %h", i, r, er[i]);
      end
      asserts++;
      if (lat != 33) begin fails++; $display("FAIL signed_latency[%0d]: got %0d want 33", i, lat); end
    end
    run_div(32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, q, r, z, lat, bc);
    asserts++;
    if (q !== 32'd1 || r !== 32'd0) begin
      fails++; $display("FAIL unsigned_big: got q=%h r=%h want q=1 r=0", q, r);
    end
  endtask

  task automatic test_div_by_zero();
    logic [31:0] q, r;
    logic z;
    int lat, bc;
    for (int s = 0; s < 2; s++) begin
      run_div(32'd5, 32'd0, 1'(s), q, r, z, lat, bc);
      asserts++;
      if (q !== 32'hFFFF_FFFF) begin
        fails++; $display("FAIL dbz_quot[s=%0d]: got %h want ffffffff", s, q);
      end
      asserts++;
      if (r !== 32'd5) begin fails++; $display("FAIL dbz_rem[s=%0d]: got %h want 5", s, r); end
      asserts++;
      if (z !== 1'b1) begin fails++; $display("FAIL dbz_flag[s=%0d]: got %b want 1", s, z); end
      asserts++;
      if (lat != 1 || bc != 1) begin
        fails++; $display("FAIL dbz_latency[s=%0d]: got lat=%0d busy=%0d want 1/1", s, lat, bc);
      end
      // Flag must be held after done falls.
      @(negedge clk);
      asserts++;
      if (div_by_zero !== 1'b1) begin
        fails++; $display("FAIL dbz_held[s=%0d]: got %b want 1", s, div_by_zero);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] q, r;
    logic z;
    int lat, bc;
    bit seen_done;
    @(negedge clk);
    start = 1'b1;
    a     = 32'h1234_5678;
    b     = 32'd3;
    is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    asserts++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
      fails++; $display("FAIL midreset_ctrl: got busy=%b done=%b dbz=%b want 0/0/0",
                        busy, done, div_by_zero);
    end
    asserts++;
    if (quotient !== 32'h0 || remainder !== 32'h0) begin
      fails++; $display("FAIL midreset_result: got q=%h r=%h want 0/0", quotient, remainder);
    end
    @(negedge clk);
    rst = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    asserts++;
    if (seen_done) begin fails++; $display("FAIL midreset_no_done: got activity want none"); end
    run_div(32'd1000, 32'd10, 1'b0, q, r, z, lat, bc);
    asserts++;
    if (q !== 32'd100 || r !== 32'd0 || lat != 33) begin
      fails++; $display("FAIL after_reset_div: got q=%0d r=%0d lat=%0d want 100/0/33", q, r, lat);
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] eq, er;
    logic ez;
    int lat, bc;
    model(32'hDEAD_BEEF, 32'd1234, 1'b0, eq, er, ez);
    @(negedge clk);
    start = 1'b1;
    a = 32'hDEAD_BEEF;
    b = 32'd1234;
    is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    a = 32'd77;
    b = 32'd0;
    is_signed = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    asserts++;
    if (quotient !== eq || remainder !== er || div_by_zero !== 1'b0) begin
      fails++; $display("FAIL ignored_start: got q=%h r=%h z=%b want q=%h r=%h z=0",
                        quotient, remainder, div_by_zero, eq, er);
    end
    asserts++;
    if (lat + 5 != 33) begin fails++; $display("FAIL ignored_latency: got %0d want 33", lat + 5); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q, r, eq, er;
    logic z, ez;
    int lat, bc;
    run_div(32'd500, 32'd9, 1'b0, q, r, z, lat, bc);
    // Now in the done cycle: present the next request.
    start = 1'b1;
    a = 32'hFFFF_FF00;
    b = 32'd7;
    is_signed = 1'b1;
    model(32'hFFFF_FF00, 32'd7, 1'b1, eq, er, ez);
    @(negedge clk);
    start = 1'b0;
    asserts++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL b2b_accept: got done=%b busy=%b want 0/1", done, busy);
    end
    wait_done(lat, bc);
    asserts++;
    if (quotient !== eq || remainder !== er || lat != 33) begin
      fails++; $display("FAIL b2b_result: got q=%h r=%h lat=%0d want q=%h r=%h lat=33",
                        quotient, remainder, lat, eq, er);
    end
  endtask

  task automatic test_random();
    logic [31:0] ra, rb, q, r, eq, er;
    logic rs, z, ez;
    int lat, bc, sel;
    for (int i = 0; i < 60; i++) begin
      ra  = $urandom;
      sel = int'($urandom_range(0, 7));
      if (sel == 0) rb = 32'd0;
      else if (sel < 3) rb = $urandom_range(1, 20);
      else if (sel == 3) rb = 32'hFFFF_FFFF;
      else rb = $urandom;
      rs = 1'($urandom);
      model(ra, rb, rs, eq, er, ez);
      run_div(ra, rb, rs, q, r, z, lat, bc);
      asserts++;
      if (q !== eq || r !== er || z !== ez) begin
        fails++; $display("FAIL random[%0d] %h/%h s=%b: got q=%h r=%h z=%b want q=%h r=%h z=%b",
                          i, ra, rb, rs, q, r, z, eq, er, ez);
      end
      asserts++;
      if (lat != (ez ? 1 : 33)) begin
        fails++; $display("FAIL random_latency[%0d]: got %0d want %0d", i, lat, ez ? 1 : 33);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_div_by_zero();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
